// File: rtl/alu_unit.sv
// 32-bit ALU with a single shared 33-bit adder and a one-cycle registered
// result stage carrying Result, four flags and an out_valid strobe.
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    input  logic        in_valid,
    output logic [31:0] Result,
    output logic        OverFlow,
    output logic        Carry,
    output logic        Zero,
    output logic        Negative,
    output logic        out_valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic        w_sub;
    logic [31:0] w_bop;
    logic [32:0] w_sum;
    logic        w_ovf_add;
    logic        w_ovf_sub;
    logic        w_lt;
    logic [31:0] w_res;
    logic        w_ovf;
    logic        w_carry;

    logic [31:0] r_result;
    logic        r_ovf;
    logic        r_carry;
    logic        r_zero;
    logic        r_neg;
    logic        r_valid;

    // SUB and SLT share the adder as A + ~B + 1
    assign w_sub = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
    assign w_bop = w_sub ? ~B : B;
    assign w_sum = {1'b0, A} + {1'b0, w_bop} + {32'd0, w_sub};

    assign w_ovf_add = (A[31] == B[31]) && (w_sum[31] != A[31]);
    assign w_ovf_sub = (A[31] != B[31]) && (w_sum[31] != A[31]);
    assign w_lt      = w_sum[31] ^ w_ovf_sub;

    always_comb begin
        w_res   = 32'd0;
        w_ovf   = 1'b0;
        w_carry = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                w_res   = w_sum[31:0];
                w_ovf   = w_ovf_add;
                w_carry = w_sum[32];
            end
            OP_SUB: begin
                w_res   = w_sum[31:0];
                w_ovf   = w_ovf_sub;
                w_carry = w_sum[32];
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_SLT:  w_res = {31'd0, w_lt};
            default: w_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= 32'd0;
            r_ovf    <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_valid  <= 1'b0;
        end else if (in_valid) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_carry  <= w_carry;
            r_zero   <= (w_res == 32'd0);
            r_neg    <= w_res[31];
            r_valid  <= 1'b1;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign Result    = r_result;
    assign OverFlow  = r_ovf;
    assign Carry     = r_carry;
    assign Zero      = r_zero;
    assign Negative  = r_neg;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases, random ops against an
// arithmetic reference model, back-to-back, hold and reset scenarios.
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic        in_valid;
    logic [31:0] Result;
    logic        OverFlow;
    logic        Carry;
    logic        Zero;
    logic        Negative;
    logic        out_valid;

    int checks;
    int errors;

    alu_unit dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .in_valid   (in_valid),
        .Result     (Result),
        .OverFlow   (OverFlow),
        .Carry      (Carry),
        .Zero       (Zero),
        .Negative   (Negative),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {Result, OverFlow, Carry, Zero, Negative} from signed/unsigned
    // integer arithmetic.
    function automatic logic [35:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [31:0] r;
        logic        v;
        logic        c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = 32'd0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: begin
                r = a + b;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                c = (ua + ub) >= 64'h1_0000_0000;
            end
            3'd1: begin
                r = a - b;
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                c = (a >= b);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {r, v, c, (r == 32'd0), r[31]};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        logic [36:0] got;
        rst = 1'b0;
        in_valid = 1'b1;
        A = 32'h1234_5678;
        B = 32'h1;
        ALUControl = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
        checks++;
        if (got !== 37'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, 37'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
        checks++;
        if (got !== 37'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got %h expected %h", got, 37'd0);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5,
                                  3'd5, 3'd5, 3'd0, 3'd1, 3'd6};
        logic [31:0] as  [10] = '{32'h5, 32'h7, 32'hF0F0F0F0, 32'hAAAAAAAA,
                                  32'h1, 32'hFFFFFFFE, 32'h2, 32'h7FFFFFFF,
                                  32'h80000000, 32'h12345678};
        logic [31:0] bs  [10] = '{32'h3, 32'h2, 32'h0F0F0F0F, 32'h55555555,
                                  32'h2, 32'hFFFFFFFF, 32'h1, 32'h1,
                                  32'h1, 32'h12345678};
        logic [35:0] exp [10] = '{
            {32'h8,        1'b0, 1'b0, 1'b0, 1'b0},
            {32'h5,        1'b0, 1'b1, 1'b0, 1'b0},
            {32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            {32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1},
            {32'h1,        1'b0, 1'b0, 1'b0, 1'b0},
            {32'h1,        1'b0, 1'b0, 1'b0, 1'b0},
            {32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            {32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1},
            {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0},
            {32'h0,        1'b0, 1'b0, 1'b1, 1'b0}};
        logic [36:0] got;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            A = as[i];
            B = bs[i];
            ALUControl = ops[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
            checks++;
            if (got !== {exp[i], 1'b1}) begin
                errors++;
                $display("FAIL directed_%0d op=%0d: got %h expected %h",
                         i, ops[i], got, {exp[i], 1'b1});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [36:0] got;
        logic [35:0] e;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            A = pick_operand();
            B = pick_operand();
            ALUControl = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
            e = model(ALUControl, A, B);
            @(posedge clk);
            #1;
            got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
            checks++;
            if (got !== {e, 1'b1}) begin
                errors++;
                $display("FAIL random_%0d op=%0d A=%h B=%h: got %h expected %h",
                         i, ALUControl, A, B, got, {e, 1'b1});
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
                checks++;
                if (got !== {e, 1'b0}) begin
                    errors++;
                    $display("FAIL random_idle_%0d: got %h expected %h",
                             i, got, {e, 1'b0});
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [36:0] got;
        logic [35:0] e;
        @(negedge clk);
        in_valid = 1'b1;
        A = $urandom;
        B = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
        for (int i = 0; i < 50; i++) begin
            e = model(ALUControl, A, B);
            @(posedge clk);
            #1;
            got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
            checks++;
            if (got !== {e, 1'b1}) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h expected %h",
                         i, got, {e, 1'b1});
            end
            A = pick_operand();
            B = pick_operand();
            ALUControl = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [36:0] got;
        logic [35:0] e;
        @(negedge clk);
        A = 32'h0000_0010;
        B = 32'h0000_0020;
        ALUControl = 3'd1;
        in_valid = 1'b1;
        e = model(3'd1, 32'h10, 32'h20);
        @(posedge clk);
        #1;
        A = 32'hDEAD_BEEF;
        ALUControl = 3'd3;
        #2;
        got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
        checks++;
        if (got !== {e, 1'b1}) begin
            errors++;
            $display("FAIL mid_cycle_change: got %h expected %h", got, {e, 1'b1});
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = $urandom;
            B = $urandom;
            ALUControl = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
            checks++;
            if (got !== {e, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d: got %h expected %h", i, got, {e, 1'b0});
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [36:0] got;
        @(negedge clk);
        A = 32'hFFFF_FFFF;
        B = 32'h0000_0000;
        ALUControl = 3'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
        checks++;
        if (got !== 37'd0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", got, 37'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
        checks++;
        if (got !== 37'd0) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", got, 37'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = {Result, OverFlow, Carry, Zero, Negative, out_valid};
            checks++;
            if (got !== 37'd0) begin
                errors++;
                $display("FAIL post_reset_%0d: got %h expected %h", i, got, 37'd0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        A = 32'd0;
        B = 32'd0;
        ALUControl = 3'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
